// File: rtl/enemy_spawner.sv
// Enemy spawn/attack sequencer: an enemy appears after an idle gap at an LFSR-chosen
// lane, strikes the player if it survives its attack window, or is killed for score.
module enemy_spawner #(
  parameter int unsigned SPAWN_GAP   = 8,
  parameter int unsigned ATTACK_TIME = 32,
  parameter int unsigned HIT_LEN     = 4,
  parameter logic [4:0]  LFSR_SEED   = 5'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       kill,
  output logic [4:0] pos_1,
  output logic       hit_1,
  output logic       active,
  output logic       score_inc,
  output logic [3:0] hit_cnt
);

  // state   | meaning
  // S_IDLE  | no enemy; counting ticks until the next spawn
  // S_ALIVE | enemy on screen; counting ticks until it strikes, killable
  // S_HIT   | enemy striking the player for HIT_LEN ticks
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIVE = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;

  localparam logic [7:0] GAP_TC    = 8'(SPAWN_GAP - 1);
  localparam logic [7:0] ATTACK_TC = 8'(ATTACK_TIME - 1);
  localparam logic [7:0] HIT_TC    = 8'(HIT_LEN - 1);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [4:0] r_lfsr;

  logic [1:0] w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_spawn;
  logic       w_hit_start;
  logic       w_kill_ok;
  logic       w_tick;
  logic [4:0] w_lfsr_nxt;
  logic [4:0] w_spawn_pos;

  assign w_tick      = tick & enable;
  assign w_lfsr_nxt  = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  // Fold LFSR values 23..31 back into the 1..22 lane range.
  assign w_spawn_pos = (r_lfsr <= 5'd22) ? r_lfsr : (r_lfsr - 5'd22);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_spawn     = 1'b0;
    w_hit_start = 1'b0;
    w_kill_ok   = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tick) begin
            if (r_cnt == GAP_TC) begin
              w_state_nxt = S_ALIVE;
              w_cnt_nxt   = 8'd0;
              w_spawn     = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        S_ALIVE: begin
          // A kill beats an attack expiry landing on the same edge.
          if (kill) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
            w_kill_ok   = 1'b1;
          end else if (tick) begin
            if (r_cnt == ATTACK_TC) begin
              w_state_nxt = S_HIT;
              w_cnt_nxt   = 8'd0;
              w_hit_start = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        S_HIT: begin
          if (tick) begin
            if (r_cnt == HIT_TC) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_lfsr    <= LFSR_SEED;
      pos_1     <= 5'd0;
      hit_1     <= 1'b0;
      active    <= 1'b0;
      score_inc <= 1'b0;
      hit_cnt   <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_tick) begin
        r_lfsr <= w_lfsr_nxt;
      end
      if (w_spawn) begin
        pos_1 <= w_spawn_pos;
      end
      if (w_hit_start && (hit_cnt != 4'd15)) begin
        hit_cnt <= hit_cnt + 4'd1;
      end
      // Flags track the state being entered so they line up with it cycle for cycle.
      hit_1     <= (w_state_nxt == S_HIT);
      active    <= (w_state_nxt != S_IDLE);
      score_inc <= w_kill_ok;
    end
  end

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner: stimulus queues expected output snapshots,
// a monitor pops and compares one on every observed output change.
module tb_enemy_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       enable;
  logic       kill;
  logic [4:0] pos_1;
  logic       hit_1;
  logic       active;
  logic       score_inc;
  logic [3:0] hit_cnt;

  enemy_spawner dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .enable    (enable),
    .kill      (kill),
    .pos_1     (pos_1),
    .hit_1     (hit_1),
    .active    (active),
    .score_inc (score_inc),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [4:0] pos;
    logic       hit;
    logic       act;
    logic       sc;
    logic [3:0] hc;
  } snap_t;

  snap_t q_s[$];
  int    q_c[$];
  string q_n[$];

  int n_checks = 0;
  int n_fail   = 0;
  int t_cnt    = 0;
  int gap      = 4;
  logic [4:0] e_pos = 5'd0;
  logic [3:0] e_hc  = 4'd0;

  // LFSR values seen before each tick, starting from the 5'h15 seed (period 31).
  int lfsr_seq [31] = '{21, 10, 20, 8, 16, 1, 2, 4, 9, 18, 5, 11, 22, 12, 25, 19,
                        7, 15, 31, 30, 28, 24, 17, 3, 6, 13, 27, 23, 14, 29, 26};

  function automatic logic [4:0] pos_of(input int k);
    int v;
    v = lfsr_seq[(k - 1) % 31];
    return (v > 22) ? 5'(v - 22) : 5'(v);
  endfunction

  task automatic push_exp(input string nm, input logic h, input logic a, input logic s,
                          input int c);
    q_s.push_back({e_pos, h, a, s, e_hc});
    q_c.push_back(c);
    q_n.push_back(nm);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (enable) t_cnt++;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic idle_to_spawn(input string nm);
    repeat (7) do_tick();
    e_pos = pos_of(t_cnt + 1);
    push_exp(nm, 1'b0, 1'b1, 1'b0, cyc + 1);
    do_tick();
  endtask

  task automatic alive_to_hit(input string nm);
    repeat (31) do_tick();
    if (e_hc != 4'd15) e_hc++;
    push_exp(nm, 1'b1, 1'b1, 1'b0, cyc + 1);
    do_tick();
  endtask

  task automatic hit_to_idle(input string nm);
    repeat (3) do_tick();
    push_exp(nm, 1'b0, 1'b0, 1'b0, cyc + 1);
    do_tick();
  endtask

  task automatic kill_pulse(input logic with_tick, input logic scored, input string nm);
    if (scored) begin
      push_exp({nm, "_pulse"}, 1'b0, 1'b0, 1'b1, cyc + 1);
      push_exp({nm, "_end"},   1'b0, 1'b0, 1'b0, cyc + 2);
    end
    kill = 1'b1;
    tick = with_tick;
    @(negedge clk);
    kill = 1'b0;
    tick = 1'b0;
    if (with_tick && enable) t_cnt++;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Monitor: every change on the outputs must match the next queued expectation.
  initial begin
    snap_t cur, prev, ex;
    int    ec;
    string en;
    bit    first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur = {pos_1, hit_1, active, score_inc, hit_cnt};
      if (first || (cur !== prev)) begin
        first = 1'b0;
        n_checks++;
        if (q_s.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got pos=%0d hit=%0b act=%0b sc=%0b hc=%0d at cycle %0d, required no change",
                   cur.pos, cur.hit, cur.act, cur.sc, cur.hc, cyc);
        end else begin
          ex = q_s.pop_front();
          ec = q_c.pop_front();
          en = q_n.pop_front();
          if ((cur !== ex) || ((ec >= 0) && (ec != cyc))) begin
            n_fail++;
            $display("FAIL %s: got pos=%0d hit=%0b act=%0b sc=%0b hc=%0d at cycle %0d, required pos=%0d hit=%0b act=%0b sc=%0b hc=%0d at cycle %0d",
                     en, cur.pos, cur.hit, cur.act, cur.sc, cur.hc, cyc,
                     ex.pos, ex.hit, ex.act, ex.sc, ex.hc, ec);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    tick   = 1'b0;
    kill   = 1'b0;
    push_exp("reset_state", 1'b0, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    idle_to_spawn("first_spawn_pos4");
    alive_to_hit("hit_after_32_ticks");
    hit_to_idle("hit_ends_after_4_ticks");

    idle_to_spawn("spawn2_pos6");
    repeat (9) do_tick();
    kill_pulse(1'b1, 1'b1, "kill_10th_alive_tick");

    idle_to_spawn("spawn3_pos4");
    repeat (31) do_tick();
    kill_pulse(1'b1, 1'b1, "kill_with_expiry");

    idle_to_spawn("spawn4_pos7");
    kill_pulse(1'b0, 1'b1, "kill_without_tick");
    kill_pulse(1'b0, 1'b0, "kill_in_idle");

    idle_to_spawn("spawn5_pos6");
    alive_to_hit("second_hit");
    kill_pulse(1'b1, 1'b0, "kill_in_hit");
    do_tick();
    push_exp("enable_drop_in_hit", 1'b0, 1'b0, 1'b0, cyc + 1);
    enable = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    idle_to_spawn("spawn_after_reenable_pos16");

    repeat (2) do_tick();
    @(posedge clk);
    #2;
    e_pos = 5'd0;
    e_hc  = 4'd0;
    push_exp("async_reset_mid_alive", 1'b0, 1'b0, 1'b0, cyc);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    t_cnt = 0;
    @(negedge clk);
    idle_to_spawn("spawn_after_reset_pos4");

    gap = 1;
    alive_to_hit("sat_hit");
    hit_to_idle("sat_idle");
    for (int i = 0; i < 15; i++) begin
      idle_to_spawn("sat_spawn");
      alive_to_hit("sat_hit");
      hit_to_idle("sat_idle");
    end

    repeat (4) @(negedge clk);
    n_checks++;
    if (q_s.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d unconsumed, required 0", q_s.size());
    end
    n_checks++;
    if (hit_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL hit_cnt_saturated: got %0d, required 15", hit_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
